// File: rtl/grn_node_lut.sv
// Gene-regulatory-network node: two Boolean state copies updated through a runtime LUT.
// Optional GRN_NODE_PERTURB_EN adds force_en/force_val to override the LUT output.
module grn_node_lut #(
  parameter int unsigned NUM_IN     = 2,
  parameter logic [(1 << NUM_IN)-1:0] LUT_INIT = 4'b1010,
  parameter int unsigned S0_PERIOD  = 2,
  parameter int unsigned STABLE_THR = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     reset_nos,
  input  logic                     init_state,
  input  logic                     start_s0,
  input  logic                     start_s1,
  input  logic [NUM_IN-1:0]        in_s0,
  input  logic [NUM_IN-1:0]        in_s1,
  input  logic                     lut_wr,
  input  logic [(1 << NUM_IN)-1:0] lut_data,
`ifdef GRN_NODE_PERTURB_EN
  input  logic                     force_en,
  input  logic                     force_val,
`endif
  output logic                     s0,
  output logic                     s1,
  output logic                     out_s0,
  output logic                     out_s1,
  output logic                     stable,
  output logic [CNT_W-1:0]         toggles
);

  localparam int unsigned LUT_D = 1 << NUM_IN;
  localparam int unsigned PH_W  = (S0_PERIOD > 1) ? $clog2(S0_PERIOD) : 1;
  localparam int unsigned SC_W  = $clog2(STABLE_THR + 1);

  logic [LUT_D-1:0] lut_q, lut_d;
  logic             s0_q, s0_d;
  logic             s1_q, s1_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [SC_W-1:0]  stable_cnt_q, stable_cnt_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] toggles_q, toggles_d;
  logic             nxt_s0, nxt_s1;

  // Candidate next values; always read from the LUT as it stood before this edge.
  always_comb begin
    nxt_s0 = lut_q[in_s0];
    nxt_s1 = lut_q[in_s1];
`ifdef GRN_NODE_PERTURB_EN
    if (force_en) begin
      nxt_s0 = force_val;
      nxt_s1 = force_val;
    end
`endif
  end

  always_comb begin
    lut_d        = lut_q;
    s0_d         = s0_q;
    s1_d         = s1_q;
    phase_d      = phase_q;
    stable_cnt_d = stable_cnt_q;
    toggles_d    = toggles_q;

    if (reset_nos) begin
      s0_d         = init_state;
      s1_d         = init_state;
      phase_d      = '0;
      stable_cnt_d = '0;
      toggles_d    = '0;
    end else begin
      if (start_s0) begin
        if (phase_q == '0) s0_d = nxt_s0;
        phase_d = (phase_q == PH_W'(S0_PERIOD - 1)) ? '0 : phase_q + PH_W'(1);
      end
      if (start_s1) begin
        s1_d = nxt_s1;
        if (nxt_s1 == s1_q) begin
          if (stable_cnt_q != SC_W'(STABLE_THR)) stable_cnt_d = stable_cnt_q + SC_W'(1);
        end else begin
          stable_cnt_d = '0;
          if (toggles_q != '1) toggles_d = toggles_q + CNT_W'(1);
        end
      end
    end

    if (lut_wr) lut_d = lut_data;

    stable_d = (stable_cnt_d == SC_W'(STABLE_THR));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lut_q        <= LUT_INIT;
      s0_q         <= 1'b0;
      s1_q         <= 1'b0;
      phase_q      <= '0;
      stable_cnt_q <= '0;
      stable_q     <= 1'b0;
      toggles_q    <= '0;
    end else begin
      lut_q        <= lut_d;
      s0_q         <= s0_d;
      s1_q         <= s1_d;
      phase_q      <= phase_d;
      stable_cnt_q <= stable_cnt_d;
      stable_q     <= stable_d;
      toggles_q    <= toggles_d;
    end
  end

  assign s0      = s0_q;
  assign s1      = s1_q;
  assign out_s0  = s0_q;
  assign out_s1  = s1_q;
  assign stable  = stable_q;
  assign toggles = toggles_q;

endmodule

// File: tb/tb_grn_node_lut.sv
// Bench for grn_node_lut: behavioural node model checked every cycle plus pinned literals.
module tb_grn_node_lut;

  localparam int unsigned NUM_IN     = 2;
  localparam int unsigned S0_PERIOD  = 2;
  localparam int unsigned STABLE_THR = 4;
  localparam int unsigned CNT_W      = 16;

  logic             clk = 1'b0;
  logic             rst, reset_nos, init_state, start_s0, start_s1, lut_wr;
  logic [1:0]       in_s0, in_s1;
  logic [3:0]       lut_data;
`ifdef GRN_NODE_PERTURB_EN
  logic             force_en, force_val;
`endif
  logic             s0, s1, out_s0, out_s1, stable;
  logic [CNT_W-1:0] toggles;

  grn_node_lut #(
    .NUM_IN(NUM_IN), .LUT_INIT(4'b1010), .S0_PERIOD(S0_PERIOD),
    .STABLE_THR(STABLE_THR), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .reset_nos(reset_nos), .init_state(init_state),
    .start_s0(start_s0), .start_s1(start_s1), .in_s0(in_s0), .in_s1(in_s1),
    .lut_wr(lut_wr), .lut_data(lut_data),
`ifdef GRN_NODE_PERTURB_EN
    .force_en(force_en), .force_val(force_val),
`endif
    .s0(s0), .s1(s1), .out_s0(out_s0), .out_s1(out_s1),
    .stable(stable), .toggles(toggles)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endfunction

  // Model: node state as counts of pulses and unchanged-update run length.
  logic [3:0] m_lut;
  logic       m_s0, m_s1, m_v;
  int         m_pulses, m_run, m_tog;

  always @(posedge clk) begin
    if (rst) begin
      m_lut = 4'b1010; m_s0 = 0; m_s1 = 0; m_pulses = 0; m_run = 0; m_tog = 0;
    end else begin
      logic [3:0] old;
      old = m_lut;
      if (reset_nos) begin
        m_s0 = init_state; m_s1 = init_state; m_pulses = 0; m_run = 0; m_tog = 0;
      end else begin
        if (start_s0) begin
          m_v = old[in_s0];
`ifdef GRN_NODE_PERTURB_EN
          if (force_en) m_v = force_val;
`endif
          if (m_pulses % S0_PERIOD == 0) m_s0 = m_v;
          m_pulses++;
        end
        if (start_s1) begin
          m_v = old[in_s1];
`ifdef GRN_NODE_PERTURB_EN
          if (force_en) m_v = force_val;
`endif
          if (m_v == m_s1) m_run++;
          else begin
            m_run = 0;
            if (m_tog < (1 << CNT_W) - 1) m_tog++;
          end
          m_s1 = m_v;
        end
      end
      if (lut_wr) m_lut = lut_data;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("s0", 32'(s0), 32'(m_s0));
      check("s1", 32'(s1), 32'(m_s1));
      check("out_s0", 32'(out_s0), 32'(m_s0));
      check("out_s1", 32'(out_s1), 32'(m_s1));
      check("stable", 32'(stable), 32'(m_run >= STABLE_THR));
      check("toggles", 32'(toggles), 32'(m_tog));
    end
  end

  // Drive one cycle of inputs just after a rising edge; return 1 time unit after the next.
  task automatic step(input logic rn, input logic init, input logic st0, input logic [1:0] i0,
                      input logic st1, input logic [1:0] i1, input logic wr, input logic [3:0] d);
    reset_nos = rn; init_state = init; start_s0 = st0; in_s0 = i0;
    start_s1 = st1; in_s1 = i1; lut_wr = wr; lut_data = d;
    @(posedge clk); #1;
    reset_nos = 0; start_s0 = 0; start_s1 = 0; lut_wr = 0;
  endtask

  initial begin
    rst = 1; reset_nos = 0; init_state = 0; start_s0 = 0; start_s1 = 0;
    in_s0 = 0; in_s1 = 0; lut_wr = 0; lut_data = 0;
`ifdef GRN_NODE_PERTURB_EN
    force_en = 0; force_val = 0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk_en = 1;
    check("rst_s0", 32'(s0), 0);
    check("rst_stable", 32'(stable), 0);
    check("rst_toggles", 32'(toggles), 0);

    step(1, 1, 0, 0, 0, 0, 0, 0);
    check("nos_s0", 32'(s0), 1);
    check("nos_s1", 32'(s1), 1);
    check("nos_toggles", 32'(toggles), 0);

    // Period-2 s0 path: pulses 1,3,5 update; 2,4 use an index that would change s0.
    step(0, 0, 1, 2'b00, 0, 0, 0, 0);
    check("p1_s0", 32'(s0), 0);
    step(0, 0, 1, 2'b01, 0, 0, 0, 0);
    check("p2_s0", 32'(s0), 0);
    step(0, 0, 1, 2'b00, 0, 0, 0, 0);
    step(0, 0, 1, 2'b01, 0, 0, 0, 0);
    check("p4_s0", 32'(s0), 0);
    step(0, 0, 1, 2'b01, 0, 0, 0, 0);
    check("p5_s0", 32'(s0), 1);

    // LUT write concurrent with start_s1 uses the old table.
    step(0, 0, 0, 0, 1, 2'b01, 1, 4'b0110);
    check("oldlut_s1", 32'(s1), 1);
    step(0, 0, 0, 0, 1, 2'b11, 0, 0);
    check("newlut_s1", 32'(s1), 0);
    check("newlut_toggles", 32'(toggles), 1);

    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1, 2'b00, 0, 0);
      if (i == 2) check("stable_3", 32'(stable), 0);
    end
    check("stable_4", 32'(stable), 1);
    step(0, 0, 1, 2'b11, 1, 2'b01, 0, 0);
    check("unstable", 32'(stable), 0);
    check("toggles_2", 32'(toggles), 2);

    repeat (3) @(posedge clk);
    #1 check("hold_s1", 32'(s1), 1);

    // reset_nos wins over both start pulses.
    step(1, 0, 1, 2'b01, 1, 2'b01, 0, 0);
    check("nos2_s0", 32'(s0), 0);
    check("nos2_s1", 32'(s1), 0);
    check("nos2_toggles", 32'(toggles), 0);
    step(0, 0, 1, 2'b01, 1, 2'b10, 0, 0);
    check("after_nos_s0", 32'(s0), 1);
    check("after_nos_s1", 32'(s1), 1);

`ifdef GRN_NODE_PERTURB_EN
    step(0, 0, 0, 0, 0, 0, 1, 4'b0000);
    force_en = 1; force_val = 1;
    step(0, 0, 0, 0, 1, 2'b00, 0, 0);
    check("force_s1", 32'(s1), 1);
    force_en = 0;
    step(0, 0, 0, 0, 1, 2'b00, 0, 0);
    check("unforce_s1", 32'(s1), 0);
`endif

    @(negedge clk);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
